ps2_key_event: RTL

- Sits between the PS2 receiver byte stream and the calculator accumulator/operator logic.
- Turns raw set-2 scan bytes (make, F0 break prefix, E0 extended prefix) into exactly one single-cycle key event per physical key press.
- Classifies each event as digit, operator, enter or clear, so that downstream state updates once per key instead of tracking a held level.
- Suppresses typematic auto-repeat and recovers from truncated prefix sequences.

---
 rtl/ps2_key_event.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event.sv
// Converts a PS/2 set-2 scan byte stream into single-cycle classified key events (digit/op/enter/clear).
// Latency: event registered one cycle after the final byte strobe; no backpressure (strobe in, pulse out).
module ps2_key_event #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16,
    parameter int REPEAT_EN   = 0
) (
    input  logic       clk,
    input  logic       iRST_n,
    input  logic [7:0] iBYTE,
    input  logic       iBYTE_VALID,
    output logic       oKEY_VALID,
    output logic [1:0] oKEY_CLASS,
    output logic [3:0] oDIGIT,
    output logic [2:0] oOP,
    output logic       oHELD
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] CLS_DIGIT = 2'd0;
    localparam logic [1:0] CLS_OP    = 2'd1;
    localparam logic [1:0] CLS_ENTER = 2'd2;
    localparam logic [1:0] CLS_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRE_E0   = 2'd1,
        PRE_F0   = 2'd2,
        PRE_E0F0 = 2'd3
    } state_t;

    typedef struct packed {
        logic       rec;
        logic [1:0] cls;
        logic [3:0] dig;
        logic [2:0] op;
    } dec_t;

    function automatic dec_t decode(input logic [8:0] k);
        dec_t d;
        d = '0;
        case (k)
            9'h070: d = {1'b1, CLS_DIGIT, 4'd0, 3'd0};
            9'h069: d = {1'b1, CLS_DIGIT, 4'd1, 3'd0};
            9'h072: d = {1'b1, CLS_DIGIT, 4'd2, 3'd0};
            9'h07A: d = {1'b1, CLS_DIGIT, 4'd3, 3'd0};
            9'h06B: d = {1'b1, CLS_DIGIT, 4'd4, 3'd0};
            9'h073: d = {1'b1, CLS_DIGIT, 4'd5, 3'd0};
            9'h074: d = {1'b1, CLS_DIGIT, 4'd6, 3'd0};
            9'h06C: d = {1'b1, CLS_DIGIT, 4'd7, 3'd0};
            9'h075: d = {1'b1, CLS_DIGIT, 4'd8, 3'd0};
            9'h07D: d = {1'b1, CLS_DIGIT, 4'd9, 3'd0};
            9'h079: d = {1'b1, CLS_OP,    4'd0, 3'd1};
            9'h07B: d = {1'b1, CLS_OP,    4'd0, 3'd2};
            9'h07C: d = {1'b1, CLS_OP,    4'd0, 3'd3};
            9'h14A: d = {1'b1, CLS_OP,    4'd0, 3'd4};
            9'h05A,
            9'h15A: d = {1'b1, CLS_ENTER, 4'd0, 3'd0};
            9'h076: d = {1'b1, CLS_CLEAR, 4'd0, 3'd0};
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            held_q, held_d;
    logic [8:0]      hkey_q, hkey_d;
    logic            vld_q, vld_d;
    logic [1:0]      cls_q, cls_d;
    logic [3:0]      dig_q, dig_d;
    logic [2:0]      op_q, op_d;

    logic            is_make, is_break, ext;
    logic [8:0]      key;
    dec_t            dec;
    logic            repeat_hit;

    assign key        = {ext, iBYTE};
    assign dec        = decode(key);
    assign repeat_hit = held_q && (hkey_q == key) && (REPEAT_EN == 0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        ext      = 1'b0;
        if (iBYTE_VALID) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (iBYTE == 8'hE0)      state_d = PRE_E0;
                    else if (iBYTE == 8'hF0) state_d = PRE_F0;
                    else if (iBYTE != 8'hFA && iBYTE != 8'hAA) is_make = 1'b1;
                end
                PRE_E0: begin
                    if (iBYTE == 8'hF0) state_d = PRE_E0F0;
                    else if (iBYTE != 8'hE0) begin
                        is_make = 1'b1;
                        ext     = 1'b1;
                        state_d = IDLE;
                    end
                end
                PRE_F0: begin
                    is_break = 1'b1;
                    state_d  = IDLE;
                end
                PRE_E0F0: begin
                    is_break = 1'b1;
                    ext      = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // Dangling prefix: a byte arriving on the expiry cycle takes priority above.
            if (cnt_q == TO_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        held_d = held_q;
        hkey_d = hkey_q;
        vld_d  = 1'b0;
        cls_d  = cls_q;
        dig_d  = dig_q;
        op_d   = op_q;
        if (is_make && dec.rec && !repeat_hit) begin
            vld_d  = 1'b1;
            cls_d  = dec.cls;
            dig_d  = dec.dig;
            op_d   = dec.op;
            held_d = 1'b1;
            hkey_d = key;
        end
        if (is_break && held_q && (hkey_q == key)) begin
            held_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            hkey_q  <= '0;
            vld_q   <= 1'b0;
            cls_q   <= '0;
            dig_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            hkey_q  <= hkey_d;
            vld_q   <= vld_d;
            cls_q   <= cls_d;
            dig_q   <= dig_d;
            op_q    <= op_d;
        end
    end

    assign oKEY_VALID = vld_q;
    assign oKEY_CLASS = cls_q;
    assign oDIGIT     = dig_q;
    assign oOP        = op_q;
    assign oHELD      = held_q;

endmodule
